// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding a single UART transmit stream.
// Each grant holds from the first beat to tlast (or the beat limit).
// An optional one-byte source-ID header (0xA0 | id) precedes each packet.
module uart_tx_arbiter #(
    parameter  int NUM_SRC     = 4,
    parameter  int DATA_WIDTH  = 8,
    parameter  int HEADER_EN   = 1,
    parameter  int MAX_PKT_LEN = 16,
    localparam int GW          = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          overlong
);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_t;

    // Beat index of the final beat allowed in one grant.
    localparam logic [7:0] LAST_BEAT = 8'(MAX_PKT_LEN - 1);

    state_t                r_state, w_state_next;
    logic [GW-1:0]         r_grant_id, w_grant_id_next;
    logic [GW-1:0]         r_last_grant, w_last_grant_next;
    logic [7:0]            r_beat_cnt, w_beat_cnt_next;
    logic                  r_overlong, w_overlong_next;

    logic [GW-1:0]         w_pick;
    logic [GW-1:0]         w_idx;
    logic                  w_found;
    logic [DATA_WIDTH-1:0] w_src_data [NUM_SRC];
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_m_tdata;
    logic                  w_m_tvalid;

    // Per-source data slices and ready steering (ready only in DATA, only to the owner).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_src_data[gi]    = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign s_axis_tready[gi] = !rst && (r_state == ST_DATA) &&
                                       (r_grant_id == GW'(gi)) && m_axis_tready;
        end
    endgenerate

    assign w_sel_data  = w_src_data[r_grant_id];
    assign w_sel_valid = s_axis_tvalid[r_grant_id];
    assign w_sel_last  = s_axis_tlast[r_grant_id];

    // Round-robin pick: first valid source scanning upward from last_grant+1.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = GW'((int'(r_last_grant) + k) % NUM_SRC);
            if (!w_found && s_axis_tvalid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Next-state logic and the combinational output path.
    always_comb begin
        w_state_next      = r_state;
        w_grant_id_next   = r_grant_id;
        w_last_grant_next = r_last_grant;
        w_beat_cnt_next   = r_beat_cnt;
        w_overlong_next   = 1'b0;
        w_m_tdata         = '0;
        w_m_tvalid        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_id_next = w_pick;
                    w_state_next    = (HEADER_EN != 0) ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                w_m_tvalid = 1'b1;
                w_m_tdata  = DATA_WIDTH'(8'hA0) | DATA_WIDTH'(r_grant_id);
                if (m_axis_tready) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                w_m_tvalid = w_sel_valid;
                w_m_tdata  = w_sel_data;
                if (w_sel_valid && m_axis_tready) begin
                    if (w_sel_last || (r_beat_cnt == LAST_BEAT)) begin
                        // tlast wins over the limit when both land on the same beat.
                        w_state_next      = ST_IDLE;
                        w_last_grant_next = r_grant_id;
                        w_beat_cnt_next   = '0;
                        w_overlong_next   = !w_sel_last;
                    end else begin
                        w_beat_cnt_next = r_beat_cnt + 8'd1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State and bookkeeping registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= GW'(NUM_SRC - 1);
            r_beat_cnt   <= '0;
            r_overlong   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_grant_id   <= w_grant_id_next;
            r_last_grant <= w_last_grant_next;
            r_beat_cnt   <= w_beat_cnt_next;
            r_overlong   <= w_overlong_next;
        end
    end

    // Outputs are forced idle while reset is held so nothing leaks mid-reset.
    assign m_axis_tdata  = rst ? '0 : w_m_tdata;
    assign m_axis_tvalid = !rst && w_m_tvalid;
    assign busy          = !rst && (r_state != ST_IDLE);
    assign grant_id      = r_grant_id;
    assign overlong      = r_overlong;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance A (4 sources, header on,
// 4-beat limit) and instance B (2 sources, header off).
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A signals
    logic [31:0] a_tdata;
    logic [3:0]  a_tvalid, a_tlast, a_sready;
    logic [7:0]  a_mdata;
    logic        a_mvalid, a_mready, a_busy, a_ovl;
    logic [1:0]  a_gid;

    // Instance B signals
    logic [15:0] b_tdata;
    logic [1:0]  b_tvalid, b_tlast, b_sready;
    logic [7:0]  b_mdata;
    logic        b_mvalid, b_mready, b_busy, b_ovl;
    logic [0:0]  b_gid;

    uart_tx_arbiter #(.NUM_SRC(4), .DATA_WIDTH(8), .HEADER_EN(1), .MAX_PKT_LEN(4)) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tlast(a_tlast),
        .s_axis_tready(a_sready),
        .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready),
        .grant_id(a_gid), .busy(a_busy), .overlong(a_ovl)
    );

    uart_tx_arbiter #(.NUM_SRC(2), .DATA_WIDTH(8), .HEADER_EN(0), .MAX_PKT_LEN(16)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tlast(b_tlast),
        .s_axis_tready(b_sready),
        .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
        .grant_id(b_gid), .busy(b_busy), .overlong(b_ovl)
    );

    // Source beat stores: {tlast, data}
    logic [8:0] a_mem [4][32];
    int         a_wr [4];
    int         a_rd [4];
    logic [8:0] b_mem [2][8];
    int         b_wr [2];
    int         b_rd [2];

    logic [7:0] outq[$];
    logic [7:0] boutq[$];
    logic [7:0] exp_q[$];
    int         ovl_cnt = 0;
    int         errors  = 0;
    int         checks  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < 4; i++) begin
            if (a_rd[i] < a_wr[i]) begin
                a_tvalid[i]      = 1'b1;
                a_tdata[i*8 +: 8] = a_mem[i][a_rd[i]][7:0];
                a_tlast[i]       = a_mem[i][a_rd[i]][8];
            end else begin
                a_tvalid[i]      = 1'b0;
                a_tdata[i*8 +: 8] = 8'h00;
                a_tlast[i]       = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (b_rd[i] < b_wr[i]) begin
                b_tvalid[i]      = 1'b1;
                b_tdata[i*8 +: 8] = b_mem[i][b_rd[i]][7:0];
                b_tlast[i]       = b_mem[i][b_rd[i]][8];
            end else begin
                b_tvalid[i]      = 1'b0;
                b_tdata[i*8 +: 8] = 8'h00;
                b_tlast[i]       = 1'b0;
            end
        end
    endtask

    // One clock: observe handshakes at negedge, advance sources just after posedge.
    task automatic cyc();
        logic [3:0] apop;
        logic [1:0] bpop;
        @(negedge clk);
        apop = a_tvalid & a_sready;
        bpop = b_tvalid & b_sready;
        if (a_mvalid && a_mready) outq.push_back(a_mdata);
        if (b_mvalid && b_mready) boutq.push_back(b_mdata);
        if (a_ovl) ovl_cnt++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (apop[i]) a_rd[i]++;
        for (int i = 0; i < 2; i++) if (bpop[i]) b_rd[i]++;
        drive_src();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic push_a(input int s, input logic [7:0] d, input logic l);
        a_mem[s][a_wr[s]] = {l, d};
        a_wr[s]++;
        drive_src();
    endtask

    task automatic push_b(input int s, input logic [7:0] d, input logic l);
        b_mem[s][b_wr[s]] = {l, d};
        b_wr[s]++;
        drive_src();
    endtask

    task automatic cmp_stream(input string tag, input bit use_b);
        logic [7:0] got[$];
        if (use_b) got = boutq;
        else       got = outq;
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got.size()) chk($sformatf("%s_b%0d", tag, k), 32'(got[k]), 32'(exp_q[k]));
        end
        if (use_b) boutq.delete();
        else       outq.delete();
    endtask

    initial begin
        a_mready = 1'b1;
        b_mready = 1'b1;
        drive_src();

        // Reset state
        run(3);
        #1;
        chk("rst_mvalid", a_mvalid, 0);
        chk("rst_mdata",  a_mdata,  0);
        chk("rst_sready", a_sready, 0);
        chk("rst_busy",   a_busy,   0);
        chk("rst_gid",    a_gid,    0);
        chk("rst_ovl",    a_ovl,    0);
        rst = 1'b0;
        run(2);
        #1;
        chk("idle_busy", a_busy, 0);

        // Single packet from source 2
        push_a(2, 8'h11, 1'b0); push_a(2, 8'h22, 1'b0); push_a(2, 8'h33, 1'b1);
        #1;
        chk("t1_arb_mvalid", a_mvalid, 0);
        cyc(); #1;
        chk("t1_hdr_mvalid", a_mvalid, 1);
        chk("t1_hdr_mdata",  a_mdata,  8'hA2);
        chk("t1_hdr_gid",    a_gid,    2);
        chk("t1_hdr_busy",   a_busy,   1);
        chk("t1_hdr_sready", a_sready, 0);
        run(4); #1;
        chk("t1_end_busy",   a_busy,   0);
        chk("t1_end_mvalid", a_mvalid, 0);
        exp_q = '{8'hA2, 8'h11, 8'h22, 8'h33};
        cmp_stream("t1", 1'b0);

        // Round robin between sources 0 and 1, source 0 re-requesting
        push_a(0, 8'h01, 1'b0); push_a(0, 8'h02, 1'b1);
        push_a(0, 8'h05, 1'b0); push_a(0, 8'h06, 1'b1);
        push_a(1, 8'h03, 1'b0); push_a(1, 8'h04, 1'b1);
        run(16); #1;
        chk("t2_busy", a_busy, 0);
        chk("t2_gid",  a_gid,  0);
        exp_q = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h03, 8'h04, 8'hA0, 8'h05, 8'h06};
        cmp_stream("t2", 1'b0);

        // Backpressure with ready pattern 1,0,0,1 in HDR and DATA
        push_a(1, 8'h55, 1'b0); push_a(1, 8'h66, 1'b1);
        cyc();
        a_mready = 1'b0; #1;
        chk("t3_hdr_mvalid", a_mvalid, 1);
        chk("t3_hdr_mdata",  a_mdata,  8'hA1);
        cyc(); #1;
        chk("t3_hdr_hold_mdata",  a_mdata,  8'hA1);
        chk("t3_hdr_hold_mvalid", a_mvalid, 1);
        cyc();
        a_mready = 1'b1; #1;
        chk("t3_hdr_sready", a_sready, 0);
        cyc();
        a_mready = 1'b0; #1;
        chk("t3_dat_sready0", a_sready, 0);
        chk("t3_dat_mdata",   a_mdata,  8'h55);
        chk("t3_dat_mvalid",  a_mvalid, 1);
        cyc(); #1;
        chk("t3_dat_hold_mdata", a_mdata, 8'h55);
        a_mready = 1'b1; #1;
        chk("t3_dat_sready1", a_sready, 4'b0010);
        cyc();
        a_mready = 1'b0;
        cyc();
        a_mready = 1'b1;
        cyc(); #1;
        chk("t3_busy", a_busy, 0);
        exp_q = '{8'hA1, 8'h55, 8'h66};
        cmp_stream("t3", 1'b0);

        // Overlong: source 3 streams past the 4-beat limit while source 0 waits
        for (int i = 0; i < 7; i++) push_a(3, 8'h31 + 8'(i), (i == 6));
        push_a(0, 8'h0A, 1'b1);
        run(20); #1;
        chk("t4_ovl_cnt", ovl_cnt, 1);
        chk("t4_ovl_now", a_ovl, 0);
        exp_q = '{8'hA3, 8'h31, 8'h32, 8'h33, 8'h34, 8'hA0, 8'h0A, 8'hA3, 8'h35, 8'h36, 8'h37};
        cmp_stream("t4", 1'b0);

        // tlast on the limit beat is a normal end
        push_a(2, 8'h41, 1'b0); push_a(2, 8'h42, 1'b0);
        push_a(2, 8'h43, 1'b0); push_a(2, 8'h44, 1'b1);
        run(8); #1;
        chk("t4b_ovl_cnt", ovl_cnt, 1);
        exp_q = '{8'hA2, 8'h41, 8'h42, 8'h43, 8'h44};
        cmp_stream("t4b", 1'b0);

        // Reset after the 2nd data beat of a 5-beat packet
        for (int i = 0; i < 5; i++) push_a(1, 8'h71 + 8'(i), (i == 4));
        run(4);
        exp_q = '{8'hA1, 8'h71, 8'h72};
        cmp_stream("t5_pre", 1'b0);
        rst = 1'b1;
        push_a(0, 8'h0B, 1'b1);
        #1;
        chk("t5_rst_mvalid", a_mvalid, 0);
        chk("t5_rst_mdata",  a_mdata,  0);
        chk("t5_rst_sready", a_sready, 0);
        chk("t5_rst_busy",   a_busy,   0);
        cyc();
        rst = 1'b0; #1;
        chk("t5_post_busy",   a_busy,   0);
        chk("t5_post_mvalid", a_mvalid, 0);
        chk("t5_post_gid",    a_gid,    0);
        cyc(); #1;
        chk("t5_regrant_mdata", a_mdata, 8'hA0);
        chk("t5_regrant_gid",   a_gid,   0);
        run(10); #1;
        chk("t5_busy", a_busy, 0);
        exp_q = '{8'hA0, 8'h0B, 8'hA1, 8'h73, 8'h74, 8'h75};
        cmp_stream("t5", 1'b0);

        // Header disabled: pure data alternating between two sources
        push_b(0, 8'hC1, 1'b1); push_b(0, 8'hC3, 1'b1);
        push_b(1, 8'hC2, 1'b1); push_b(1, 8'hC4, 1'b1);
        #1;
        chk("t6_arb_mvalid", b_mvalid, 0);
        cyc(); #1;
        chk("t6_first_mvalid", b_mvalid, 1);
        chk("t6_first_mdata",  b_mdata,  8'hC1);
        chk("t6_first_gid",    b_gid,    0);
        run(10); #1;
        chk("t6_busy", b_busy, 0);
        exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        cmp_stream("t6", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
